// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver with frame-synchronous double buffering.
// Define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 is always shown).
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] DataIn,
    input  logic        Load,
    output logic        Pending,
    output logic [6:0]  out7,
    output logic [3:0]  en_out
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

    localparam logic [6:0] SegBlank = 7'h7F;
    localparam logic [3:0] EnAllOff = 4'hF;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      digit_q, digit_d;
    logic [15:0]     disp_q, disp_d;
    logic [15:0]     pend_q, pend_d;
    logic            pend_v_q, pend_v_d;
    logic [6:0]      out7_q, out7_d;
    logic [3:0]      en_out_q, en_out_d;

    logic            tick;
    logic            frame_end;
    logic [3:0]      cur_nib;
    logic            blank;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        seg = SegBlank;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SegBlank;
        endcase
        return seg;
    endfunction

    assign tick      = (cnt_q == CntMax);
    assign frame_end = tick && (digit_q == 2'd3);
    assign cur_nib   = disp_q[{digit_q, 2'b00} +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every more-significant nibble are zero.
    always_comb begin
        blank = 1'b0;
        case (digit_q)
            2'd3:    blank = (disp_q[15:12] == 4'h0);
            2'd2:    blank = (disp_q[15:8] == 8'h00);
            2'd1:    blank = (disp_q[15:4] == 12'h000);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        digit_d  = tick ? digit_q + 2'd1 : digit_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        disp_d   = disp_q;

        if (Load) begin
            pend_d   = DataIn;
            pend_v_d = 1'b1;
        end

        // A load landing on the frame boundary bypasses the pending buffer.
        if (frame_end) begin
            if (Load) begin
                disp_d = DataIn;
            end else if (pend_v_q) begin
                disp_d = pend_q;
            end
            pend_v_d = 1'b0;
        end

        en_out_d = ~(4'b0001 << digit_q);
        out7_d   = blank ? SegBlank : hex_to_seg(cur_nib);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt_q    <= '0;
            digit_q  <= 2'd0;
            disp_q   <= 16'h0000;
            pend_q   <= 16'h0000;
            pend_v_q <= 1'b0;
            out7_q   <= SegBlank;
            en_out_q <= EnAllOff;
        end else begin
            cnt_q    <= cnt_d;
            digit_q  <= digit_d;
            disp_q   <= disp_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            out7_q   <= out7_d;
            en_out_q <= en_out_d;
        end
    end

    assign Pending = pend_v_q;
    assign out7    = out7_q;
    assign en_out  = en_out_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a cycle-count based display model.
// Honours SEG7_LEADING_ZERO_BLANK_EN in the model when the macro is defined.
module tb_seg7_scan_driver;

    localparam int unsigned DIV   = 4;
    localparam int unsigned FRAME = 4 * DIV;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        Clock;
    logic        Reset;
    logic [15:0] DataIn;
    logic        Load;
    logic        Pending;
    logic [6:0]  out7;
    logic [3:0]  en_out;

    int unsigned n_tests;
    int unsigned n_fail;

    // Model state: edges since reset release, shown value, pending buffer.
    int unsigned cyc;
    logic [15:0] disp_m;
    logic [15:0] pend_m;
    logic        pv_m;

    seg7_scan_driver #(
        .REFRESH_DIV(DIV)
    ) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .DataIn (DataIn),
        .Load   (Load),
        .Pending(Pending),
        .out7   (out7),
        .en_out (en_out)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s (cyc %0d): got %0h, expected %0h", tag, cyc, obs, expv);
        end
    endtask

    function automatic logic [6:0] model_seg(input logic [15:0] v, input int unsigned k);
        int unsigned upper;
        logic [3:0]  nib;
        upper = 32'(v) >> (4 * k);
        nib   = 4'(upper & 32'hF);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (k != 0 && upper == 0) return 7'h7F;
`endif
        return SEG_TAB[nib];
    endfunction

    task automatic model_reset();
        cyc    = 0;
        disp_m = 16'h0000;
        pend_m = 16'h0000;
        pv_m   = 1'b0;
    endtask

    // Called just after a falling edge; drives inputs, checks the following rising edge.
    task automatic step(input logic ld, input logic [15:0] din);
        int unsigned slot;
        logic [6:0]  e7;
        logic [3:0]  een;
        Load   = ld;
        DataIn = din;
        slot   = (cyc / DIV) % 4;
        e7     = model_seg(disp_m, slot);
        een    = ~(4'b0001 << slot);
        if (ld) begin
            pend_m = din;
            pv_m   = 1'b1;
        end
        if (cyc % FRAME == FRAME - 1) begin
            if (ld) disp_m = din;
            else if (pv_m) disp_m = pend_m;
            pv_m = 1'b0;
        end
        cyc++;
        @(posedge Clock);
        #1;
        check_eq("out7", 32'(out7), 32'(e7));
        check_eq("en_out", 32'(en_out), 32'(een));
        check_eq("pending", 32'(Pending), 32'(pv_m));
        @(negedge Clock);
    endtask

    task automatic idle(input int unsigned n);
        for (int i = 0; i < int'(n); i++) step(1'b0, 16'($urandom));
    endtask

    task automatic align(input int unsigned phase);
        while (cyc % FRAME != phase) step(1'b0, 16'($urandom));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        Load   = 1'b0;
        DataIn = 16'h0000;
        Reset  = 1'b1;
        #2;
        Reset = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        check_eq("rst_out7", 32'(out7), 32'h7F);
        check_eq("rst_en", 32'(en_out), 32'hF);
        check_eq("rst_pend", 32'(Pending), 32'h0);

        @(negedge Clock);
        Reset = 1'b1;
        idle(3 * FRAME);

        align(5);
        step(1'b1, 16'h12AF);
        idle(3 * FRAME);

        align(2);
        step(1'b1, 16'h1111);
        idle(3);
        step(1'b1, 16'h2222);
        idle(2 * FRAME);

        align(FRAME - 1);
        step(1'b1, 16'hBEEF);
        idle(2 * FRAME);

        align(7);
        step(1'b1, 16'h0070);
        idle(2 * FRAME);

        for (int i = 0; i < 1500; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            if ($urandom_range(0, 1) == 0) d = d >> (4 * $urandom_range(1, 4));
            step($urandom_range(0, 9) == 0, d);
        end

        // Asynchronous reset in the middle of a frame with a load pending.
        align(6);
        step(1'b1, 16'h4321);
        Load  = 1'b0;
        Reset = 1'b0;
        #1;
        check_eq("mid_rst_out7", 32'(out7), 32'h7F);
        check_eq("mid_rst_en", 32'(en_out), 32'hF);
        check_eq("mid_rst_pend", 32'(Pending), 32'h0);
        model_reset();
        @(posedge Clock);
        #1;
        check_eq("hold_rst_out7", 32'(out7), 32'h7F);
        check_eq("hold_rst_en", 32'(en_out), 32'hF);
        @(negedge Clock);
        Reset = 1'b1;
        idle(2 * FRAME);

        for (int i = 0; i < 500; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            if ($urandom_range(0, 1) == 0) d = d >> (4 * $urandom_range(1, 4));
            step($urandom_range(0, 5) == 0, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
